// File: rtl/tc_ps_gp_pkg.sv
// Shared constants for the TC PS general-purpose register block.
// Holds group codes, per-group register offsets and field widths so the write
// side (tc_ps_gp_wr_data) and the read side agree on one register map.
package tc_ps_gp_pkg;

  // Group codes (address bits above the register offset)
  localparam int unsigned GrpGlobal  = 0;
  localparam int unsigned GrpCapture = 1;
  localparam int unsigned GrpLaser   = 2;
  localparam int unsigned GrpBus     = 3;
  localparam int unsigned GrpOther   = 4;

  // Global group offsets
  localparam int unsigned OffGMode   = 0;
  localparam int unsigned OffGCommit = 1;
  localparam int unsigned OffGErrClr = 2;

  // Capture group offsets (shadow registers)
  localparam int unsigned OffCEnable = 0;
  localparam int unsigned OffCPeriod = 1;
  localparam int unsigned OffCGain   = 2;
  localparam int unsigned OffCThresh = 3;

  // Laser group offsets
  localparam int unsigned OffDPower  = 0;
  localparam int unsigned OffDFire   = 1;

  // Bus group offsets
  localparam int unsigned OffBAddr   = 0;
  localparam int unsigned OffBData   = 1;
  localparam int unsigned OffBStart  = 2;

  // Other group offsets
  localparam int unsigned OffRCtrl   = 0;

  // Field widths
  localparam int unsigned WGMode    = 3;
  localparam int unsigned WCPeriod  = 32;
  localparam int unsigned WCGain    = 8;
  localparam int unsigned WCThresh  = 18;
  localparam int unsigned WDPower   = 14;
  localparam int unsigned WBAddr    = 9;
  localparam int unsigned WBData    = 16;
  localparam int unsigned WRCtrl    = 4;

  // Capture shadow select, encoded as the capture register offset
  typedef enum logic [1:0] {
    CapEnable = 2'd0,
    CapPeriod = 2'd1,
    CapGain   = 2'd2,
    CapThresh = 2'd3
  } cap_sel_e;

  // Each group's offsets are contiguous from 0, so a register exists iff the
  // offset does not exceed the group's highest offset.
  function automatic logic is_mapped(input int unsigned grp, input int unsigned off);
    case (grp)
      GrpGlobal:  return off <= OffGErrClr;
      GrpCapture: return off <= OffCThresh;
      GrpLaser:   return off <= OffDFire;
      GrpBus:     return off <= OffBStart;
      GrpOther:   return off <= OffRCtrl;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tc_gp_shadow_bank.sv
// Capture settings bank: a shadow copy written by register writes and an
// active copy that only follows the shadows on a commit.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   wr_i, sel_i      shadow write strobe and target select
//   data_i           write data (each field takes its LSBs)
//   commit_i         copy all shadows into the active outputs
//   c_*_o            active capture settings
module tc_gp_shadow_bank
  import tc_ps_gp_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_i,
  input  cap_sel_e            sel_i,
  input  logic [31:0]         data_i,
  input  logic                commit_i,
  output logic                c_enable_o,
  output logic [WCPeriod-1:0] c_period_o,
  output logic [WCGain-1:0]   c_gain_o,
  output logic [WCThresh-1:0] c_thresh_o
);

  logic                en_sh_q, en_sh_d;
  logic [WCPeriod-1:0] period_sh_q, period_sh_d;
  logic [WCGain-1:0]   gain_sh_q, gain_sh_d;
  logic [WCThresh-1:0] thresh_sh_q, thresh_sh_d;

  logic                en_act_q, en_act_d;
  logic [WCPeriod-1:0] period_act_q, period_act_d;
  logic [WCGain-1:0]   gain_act_q, gain_act_d;
  logic [WCThresh-1:0] thresh_act_q, thresh_act_d;

  always_comb begin
    en_sh_d      = en_sh_q;
    period_sh_d  = period_sh_q;
    gain_sh_d    = gain_sh_q;
    thresh_sh_d  = thresh_sh_q;
    en_act_d     = en_act_q;
    period_act_d = period_act_q;
    gain_act_d   = gain_act_q;
    thresh_act_d = thresh_act_q;

    if (wr_i) begin
      unique case (sel_i)
        CapEnable: en_sh_d     = data_i[0];
        CapPeriod: period_sh_d = data_i[WCPeriod-1:0];
        CapGain:   gain_sh_d   = data_i[WCGain-1:0];
        CapThresh: thresh_sh_d = data_i[WCThresh-1:0];
      endcase
    end

    // Commit takes the pre-write shadows; a coincident write stays pending.
    if (commit_i) begin
      en_act_d     = en_sh_q;
      period_act_d = period_sh_q;
      gain_act_d   = gain_sh_q;
      thresh_act_d = thresh_sh_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_sh_q      <= 1'b0;
      period_sh_q  <= '0;
      gain_sh_q    <= '0;
      thresh_sh_q  <= '0;
      en_act_q     <= 1'b0;
      period_act_q <= '0;
      gain_act_q   <= '0;
      thresh_act_q <= '0;
    end else begin
      en_sh_q      <= en_sh_d;
      period_sh_q  <= period_sh_d;
      gain_sh_q    <= gain_sh_d;
      thresh_sh_q  <= thresh_sh_d;
      en_act_q     <= en_act_d;
      period_act_q <= period_act_d;
      gain_act_q   <= gain_act_d;
      thresh_act_q <= thresh_act_d;
    end
  end

  assign c_enable_o = en_act_q;
  assign c_period_o = period_act_q;
  assign c_gain_o   = gain_act_q;
  assign c_thresh_o = thresh_act_q;

endmodule

// File: rtl/tc_ps_gp_wr_data.sv
// Write side of the TC PS general-purpose register block.
// A write sampled at edge N is held in stage 1, moves to stage 2 at N+1 and
// updates its target (and raises wr_ack_o) at N+2. No stalls.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   wr_en_i/addr_i/wdata_i write strobe, address, data
//   commit_ext_i           external commit strobe (frame sync)
//   wr_ack_o               one-cycle acknowledge per write
//   wr_err_o/wr_err_addr_o sticky unmapped-write flag and first bad address
//   g_mode_o, g_commit_o   global mode, commit pulse
//   c_*_o                  active capture settings
//   d_power_o, d_fire_o    laser power level, fire pulse
//   b_addr_o/b_data_o/b_start_o  bus command, start pulse
//   r_ctrl_o               miscellaneous control
module tc_ps_gp_wr_data
  import tc_ps_gp_pkg::*;
#(
  parameter int unsigned WTH_ADDL = 10,
  parameter int unsigned WTH_ADDR = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wr_en_i,
  input  logic [WTH_ADDR-1:0] addr_i,
  input  logic [31:0]         wdata_i,
  input  logic                commit_ext_i,
  output logic                wr_ack_o,
  output logic                wr_err_o,
  output logic [WTH_ADDR-1:0] wr_err_addr_o,
  output logic [WGMode-1:0]   g_mode_o,
  output logic                g_commit_o,
  output logic                c_enable_o,
  output logic [WCPeriod-1:0] c_period_o,
  output logic [WCGain-1:0]   c_gain_o,
  output logic [WCThresh-1:0] c_thresh_o,
  output logic [WDPower-1:0]  d_power_o,
  output logic                d_fire_o,
  output logic [WBAddr-1:0]   b_addr_o,
  output logic [WBData-1:0]   b_data_o,
  output logic                b_start_o,
  output logic [WRCtrl-1:0]   r_ctrl_o
);

  // Pipeline stages
  logic                s1_vld_q, s2_vld_q;
  logic [WTH_ADDR-1:0] s1_addr_q, s2_addr_q;
  logic [31:0]         s1_wdata_q, s2_wdata_q;

  // Output state
  logic                wr_ack_q, wr_ack_d;
  logic                wr_err_q, wr_err_d;
  logic [WTH_ADDR-1:0] wr_err_addr_q, wr_err_addr_d;
  logic [WGMode-1:0]   g_mode_q, g_mode_d;
  logic                g_commit_q, g_commit_d;
  logic [WDPower-1:0]  d_power_q, d_power_d;
  logic                d_fire_q, d_fire_d;
  logic [WBAddr-1:0]   b_addr_q, b_addr_d;
  logic [WBData-1:0]   b_data_q, b_data_d;
  logic                b_start_q, b_start_d;
  logic [WRCtrl-1:0]   r_ctrl_q, r_ctrl_d;

  // Stage-2 decode
  logic [31:0] grp, off;
  logic        in_glb, in_cap, in_las, in_bus, in_oth;
  logic        commit, err_clr, cap_wr;
  cap_sel_e    cap_sel;

  assign grp = 32'(s2_addr_q[WTH_ADDR-1:WTH_ADDL]);
  assign off = 32'(s2_addr_q[WTH_ADDL-1:0]);

  assign in_glb = s2_vld_q && (grp == GrpGlobal);
  assign in_cap = s2_vld_q && (grp == GrpCapture);
  assign in_las = s2_vld_q && (grp == GrpLaser);
  assign in_bus = s2_vld_q && (grp == GrpBus);
  assign in_oth = s2_vld_q && (grp == GrpOther);

  // Register commit and external commit merge into a single pulse.
  assign commit  = commit_ext_i || (in_glb && (off == OffGCommit) && s2_wdata_q[0]);
  assign err_clr = in_glb && (off == OffGErrClr) && s2_wdata_q[0];
  assign cap_wr  = in_cap && (off <= OffCThresh);
  assign cap_sel = cap_sel_e'(off[1:0]);

  always_comb begin
    wr_ack_d      = s2_vld_q;
    g_commit_d    = commit;
    wr_err_d      = wr_err_q;
    wr_err_addr_d = wr_err_addr_q;
    g_mode_d      = g_mode_q;
    d_power_d     = d_power_q;
    b_addr_d      = b_addr_q;
    b_data_d      = b_data_q;
    r_ctrl_d      = r_ctrl_q;
    d_fire_d      = in_las && (off == OffDFire) && s2_wdata_q[0];
    b_start_d     = in_bus && (off == OffBStart) && s2_wdata_q[0];

    if (in_glb && (off == OffGMode))  g_mode_d  = s2_wdata_q[WGMode-1:0];
    if (in_las && (off == OffDPower)) d_power_d = s2_wdata_q[WDPower-1:0];
    if (in_bus && (off == OffBAddr))  b_addr_d  = s2_wdata_q[WBAddr-1:0];
    if (in_bus && (off == OffBData))  b_data_d  = s2_wdata_q[WBData-1:0];
    if (in_oth && (off == OffRCtrl))  r_ctrl_d  = s2_wdata_q[WRCtrl-1:0];

    if (err_clr) begin
      wr_err_d      = 1'b0;
      wr_err_addr_d = '0;
    end else if (s2_vld_q && !is_mapped(grp, off)) begin
      wr_err_d = 1'b1;
      // Keep the first offending address until software clears the flag.
      if (!wr_err_q) wr_err_addr_d = s2_addr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_wdata_q    <= '0;
      s2_vld_q      <= 1'b0;
      s2_addr_q     <= '0;
      s2_wdata_q    <= '0;
      wr_ack_q      <= 1'b0;
      wr_err_q      <= 1'b0;
      wr_err_addr_q <= '0;
      g_mode_q      <= '0;
      g_commit_q    <= 1'b0;
      d_power_q     <= '0;
      d_fire_q      <= 1'b0;
      b_addr_q      <= '0;
      b_data_q      <= '0;
      b_start_q     <= 1'b0;
      r_ctrl_q      <= '0;
    end else begin
      s1_vld_q      <= wr_en_i;
      s1_addr_q     <= addr_i;
      s1_wdata_q    <= wdata_i;
      s2_vld_q      <= s1_vld_q;
      s2_addr_q     <= s1_addr_q;
      s2_wdata_q    <= s1_wdata_q;
      wr_ack_q      <= wr_ack_d;
      wr_err_q      <= wr_err_d;
      wr_err_addr_q <= wr_err_addr_d;
      g_mode_q      <= g_mode_d;
      g_commit_q    <= g_commit_d;
      d_power_q     <= d_power_d;
      d_fire_q      <= d_fire_d;
      b_addr_q      <= b_addr_d;
      b_data_q      <= b_data_d;
      b_start_q     <= b_start_d;
      r_ctrl_q      <= r_ctrl_d;
    end
  end

  tc_gp_shadow_bank u_shadow_bank (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_i       (cap_wr),
    .sel_i      (cap_sel),
    .data_i     (s2_wdata_q),
    .commit_i   (commit),
    .c_enable_o (c_enable_o),
    .c_period_o (c_period_o),
    .c_gain_o   (c_gain_o),
    .c_thresh_o (c_thresh_o)
  );

  assign wr_ack_o      = wr_ack_q;
  assign wr_err_o      = wr_err_q;
  assign wr_err_addr_o = wr_err_addr_q;
  assign g_mode_o      = g_mode_q;
  assign g_commit_o    = g_commit_q;
  assign d_power_o     = d_power_q;
  assign d_fire_o      = d_fire_q;
  assign b_addr_o      = b_addr_q;
  assign b_data_o      = b_data_q;
  assign b_start_o     = b_start_q;
  assign r_ctrl_o      = r_ctrl_q;

endmodule

// File: doc/tc_ps_gp_wr_data.md
TC_PS_GP_WR_DATA -- requirements
Module: tc_ps_gp_wr_data

Interface
REQ-001 Parameter WTH_ADDL, default 10: number of low address bits used as the register offset.
REQ-002 Parameter WTH_ADDR, default 32: address width; the group select is addr[WTH_ADDR-1:WTH_ADDL].
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 wr_en  in  1  write strobe; one write per high cycle.
REQ-006 addr  in  32  write address.
REQ-007 wdata  in  32  write data.
REQ-008 commit_ext  in  1  external commit strobe (frame sync).
REQ-009 wr_ack  out  1  one-cycle acknowledge of every accepted write.
REQ-010 wr_err  out  1  sticky flag: unmapped write seen.
REQ-011 wr_err_addr  out  32  address of the first unmapped write since the last clear.
REQ-012 g_mode  out  3  global mode, level.
REQ-013 g_commit  out  1  one-cycle pulse; capture shadows applied.
REQ-014 c_enable / c_period / c_gain / c_thresh  out  1 / 32 / 8 / 18  active capture settings.
REQ-015 d_power  out  14  laser power, level.
REQ-016 d_fire  out  1  laser fire pulse.
REQ-017 b_addr / b_data / b_start  out  9 / 16 / 1  bus command; b_start is a pulse.
REQ-018 r_ctrl  out  4  miscellaneous control, level.

Function
REQ-019 The block SHALL split addr into addr_H (high bits) and addr_L (low WTH_ADDL bits), with groups decoded as follows: addr_H 0 global, 1 capture, 2 laser, 3 bus, 4 other.
REQ-020 Pipeline: stage 1 SHALL register wr_en, addr and wdata, and stage 2 SHALL decode and update the outputs.
REQ-021 Write timing: a write sampled at edge N SHALL update its target at edge N+2, with wr_ack high for the following cycle.
REQ-022 Back-to-back writes on consecutive cycles SHALL all be accepted, in order, with no stall and no loss.
REQ-023 Register map (group:offset -> target, each field taken from wdata LSBs and truncated to its width):
- 0:0 -> g_mode
- 0:1 -> commit when wdata[0]=1
- 0:2 -> error clear when wdata[0]=1
- 1:0..3 -> shadow of c_enable, c_period, c_gain, c_thresh
- 2:0 -> d_power
- 2:1 -> d_fire pulse when wdata[0]=1
- 3:0 -> b_addr
- 3:1 -> b_data
- 3:2 -> b_start pulse when wdata[0]=1
- 4:0 -> r_ctrl
REQ-024 Capture group writes SHALL change only the shadows; the active c_* outputs SHALL update only on a commit.
REQ-025 A commit (register 0:1 or commit_ext high) SHALL copy all shadows to the active c_* outputs at the same edge and pulse g_commit for exactly one cycle.
REQ-026 If commit_ext coincides with a stage-2 shadow write, the commit SHALL use the pre-write shadow, the new value SHALL stay pending, and the write SHALL still be acked.
REQ-027 A register 0:1 commit coinciding with commit_ext SHALL produce a single g_commit pulse.
REQ-028 d_fire, b_start and g_commit SHALL be high for exactly one cycle per trigger, and back-to-back triggers SHALL give back-to-back pulses.
REQ-029 A write to any unmapped group or offset SHALL still be acked, SHALL change no output, and SHALL set wr_err.
REQ-030 wr_err_addr SHALL capture the address only if wr_err was previously clear.
REQ-031 A write to register 0:2 with wdata[0]=1 SHALL clear wr_err and wr_err_addr at the acked edge.
REQ-032 Cycles with wr_en low SHALL change nothing except commit_ext effects.

Reset
REQ-033 While rst is low, all outputs, shadows and pipeline stages SHALL be 0 immediately, without waiting for a clock edge.
REQ-034 A write that is in flight when rst asserts SHALL be discarded, and no wr_ack SHALL follow release of reset.
REQ-035 After rst deasserts, the first write accepted SHALL be the one sampled at the first rising edge with rst high.

Structure
REQ-036 Group codes, per-group offsets and field widths SHALL be constants in the shared package tc_ps_gp_pkg, which the read-side block also uses.
REQ-037 The capture shadow/active register bank with commit SHALL be one sub-module, tc_gp_shadow_bank.

Verification
REQ-038 Write 0x0000_0000 = 0x5 -> g_mode = 5 two edges later, wr_ack pulses once.
REQ-039 Write 0x0000_0401 = 0x1234, then 0x0000_0001 = 0x1:
- c_period stays 0 after the first write.
- c_period = 0x1234 and g_commit pulses one cycle after the commit.
REQ-040 Write 0x0000_0402 = 0xAB in the same stage-2 cycle as commit_ext:
- c_gain is unchanged at that edge.
- c_gain = 0xAB after the next commit_ext.
REQ-041 Write 0x0000_0801 = 0x1 on 3 consecutive cycles -> d_fire high 3 consecutive cycles, 3 wr_acks.
REQ-042 Write 0x0000_1400 = 0x7 then 0x0000_0C05 = 0x1:
- wr_err = 1 and wr_err_addr = 0x0000_1400 after both writes.
- Writing 0x0000_0002 = 0x1 clears both to 0.
REQ-043 Write 0x0000_1000 = 0xF and assert rst in the next cycle -> r_ctrl = 0, no wr_ack; after release r_ctrl stays 0.
